// File: rtl/oci_dct_sequencer_pkg.sv
// oci_dct_pkg: shared widths, atom codes and state enums for the DCT trace sequencer.
package oci_dct_pkg;
   localparam int ATOM_W = 2;
   localparam int DEPTH  = 15;
   localparam int CNT_W  = 4;
   localparam int BUF_W  = ATOM_W * DEPTH;
   localparam int FRM_W  = CNT_W + BUF_W;
   typedef enum logic [1:0] {DCT_NONE = 2'b00, DCT_NT = 2'b01, DCT_TK = 2'b10, DCT_IND = 2'b11} atom_code_t;
   typedef enum logic [1:0] {ACC_EMPTY, ACC_PART, ACC_FULL} acc_st_t;
   typedef enum logic {SLOT_EMPTY, SLOT_PEND} slot_st_t;
endpackage

// File: rtl/oci_dct_sequencer_if.sv
// oci_dct_sequencer_if: atom input and frame valid/ready bus of the DCT sequencer.
interface oci_dct_sequencer_if;
   import oci_dct_pkg::*;
   logic             atom_valid;
   atom_code_t       atom_code;
   logic             flush;
   logic             frm_valid;
   logic             frm_ready;
   logic [FRM_W-1:0] frm_data;
   modport master (output atom_valid, atom_code, flush, frm_ready, input frm_valid, frm_data);
   modport slave  (input atom_valid, atom_code, flush, frm_ready, output frm_valid, frm_data);
endinterface

// File: rtl/oci_dct_frame_slot.sv
// oci_dct_frame_slot: single-entry valid/ready holding register; can reload on the drain cycle.
module oci_dct_frame_slot
   import oci_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [FRM_W-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [FRM_W-1:0] o_data,
   output logic             o_free_next
);
   slot_st_t         r_st;
   slot_st_t         w_st_nxt;
   logic [FRM_W-1:0] r_data;
   assign o_valid     = r_st == SLOT_PEND;
   assign o_data      = r_data;
   assign o_free_next = !o_valid || i_ready;
   always_comb begin
      w_st_nxt = i_load ? SLOT_PEND : (o_valid && i_ready) ? SLOT_EMPTY : r_st;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_st   <= SLOT_EMPTY;
         r_data <= '0;
      end else begin
         r_st <= w_st_nxt;
         if (i_load) r_data <= i_data;
      end
   end
endmodule

// File: rtl/oci_dct_sequencer.sv
// oci_dct_sequencer: packs 2-bit DCT atoms into 15-atom frames for the OCI trace FIFO.
// Define OCI_DCT_OVERFLOW_CNT_EN to add the saturating dropped-atom counter ovf_count.
module oci_dct_sequencer
   import oci_dct_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   oci_dct_sequencer_if.slave bus,
   output logic [BUF_W-1:0]   dct_buffer,
   output logic [CNT_W-1:0]   dct_count,
   output logic               overflow,
   output logic               busy
`ifdef OCI_DCT_OVERFLOW_CNT_EN
   ,
   output logic [7:0]         ovf_count
`endif
);
   acc_st_t          r_acc_st;
   acc_st_t          w_acc_nxt;
   logic [BUF_W-1:0] r_buf;
   logic [CNT_W-1:0] r_cnt;
   logic             r_flush_pend;
   logic             r_ovf;
   logic             w_atom, w_take, w_drop, w_close, w_load, w_free;
   logic [BUF_W-1:0] w_buf_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   // close decisions use the accumulator as it will look after this cycle's atom
   always_comb begin
      w_atom    = bus.atom_valid && bus.atom_code != DCT_NONE;
      w_take    = w_atom && r_acc_st != ACC_FULL;
      w_drop    = w_atom && r_acc_st == ACC_FULL;
      w_buf_nxt = w_take ? {r_buf[BUF_W-ATOM_W-1:0], bus.atom_code} : r_buf;
      w_cnt_nxt = r_cnt + CNT_W'(w_take);
      w_close   = w_cnt_nxt == CNT_W'(DEPTH) || ((bus.flush || r_flush_pend) && w_cnt_nxt != '0);
      w_load    = w_close && w_free;
      w_acc_nxt = (w_load || w_cnt_nxt == '0) ? ACC_EMPTY :
                  (w_cnt_nxt == CNT_W'(DEPTH)) ? ACC_FULL : ACC_PART;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc_st     <= ACC_EMPTY;
         r_buf        <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_acc_st     <= w_acc_nxt;
         r_buf        <= w_load ? '0 : w_buf_nxt;
         r_cnt        <= w_load ? '0 : w_cnt_nxt;
         r_flush_pend <= !w_load && (r_flush_pend || (bus.flush && w_cnt_nxt != '0));
         r_ovf        <= w_drop;
      end
   end
   oci_dct_frame_slot u_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_load      (w_load),
      .i_data      ({w_cnt_nxt, w_buf_nxt}),
      .i_ready     (bus.frm_ready),
      .o_valid     (bus.frm_valid),
      .o_data      (bus.frm_data),
      .o_free_next (w_free)
   );
   assign dct_buffer = r_buf;
   assign dct_count  = r_cnt;
   assign overflow   = r_ovf;
   assign busy       = r_cnt != '0 || bus.frm_valid;
`ifdef OCI_DCT_OVERFLOW_CNT_EN
   logic [7:0] r_ovf_cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ovf_cnt <= '0;
      else if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
   end
   assign ovf_count = r_ovf_cnt;
`endif
endmodule

// File: doc/oci_dct_sequencer.md
# oci_dct_sequencer

Collects 2-bit direct-control-trace (DCT) atoms from the Nios II OCI trace path into a 30-bit packing buffer. Emits completed frames to the trace FIFO over a valid/ready handshake. It sits between the CPU's branch-resolution trace tap and the OCI trace memory. It also drives the live `dct_buffer` and `dct_count` values consumed by the OCI test bench monitor.

## Interface
Parameters:
- `ATOM_W`, 2: bits per atom.
- `DEPTH`, 15: atoms per frame. Buffer width is `ATOM_W*DEPTH` = 30.
- `CNT_W`, 4: width of the atom counter.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `atom_valid`, in, 1: an atom is presented this cycle.
- `atom_code`, in, 2: 00 none (ignored), 01 not-taken, 10 taken, 11 indirect marker.
- `flush`, in, 1: close the partial frame (exception, trace stop).
- `dct_buffer`, out, 30: live accumulator contents.
- `dct_count`, out, 4: live atom count, 0..15.
- `frm_valid`, out, 1: output frame valid.
- `frm_ready`, in, 1: trace FIFO accepts the frame.
- `frm_data`, out, 34: frame word, `{count[3:0], buffer[29:0]}`.
- `overflow`, out, 1: one-cycle pulse when an atom is dropped.
- `busy`, out, 1: accumulator non-empty or frame pending.
- `ovf_count`, out, 8: present only with the macro described under Configuration.

## Operation
- An atom is accepted when `atom_valid` is high, `atom_code` is not 00, and the accumulator is not FULL.
  - Accept action: `buffer <= {buffer[27:0], atom_code}`, then `count <= count+1`.
- Accumulator FSM:
  - EMPTY: count is 0.
  - PART: count is 1..14.
  - FULL: count is 15 and the output slot is occupied.
- Close condition: the 15th atom is accepted, or `flush` is high with count>0 (after including any atom accepted the same cycle).
  - If the slot is free, or frees this cycle because `frm_valid && frm_ready`, the accumulator transfers to the slot and resets to EMPTY.
  - Otherwise, a 15th-atom close goes to FULL. A pending flush is held in a `flush_pend` flag until the transfer completes.
- FULL: every offered atom is dropped and pulses `overflow`. The accumulator is unchanged. FULL exits to EMPTY on the transfer cycle.
- Flush with count==0 and no same-cycle atom: no frame is produced.
- Output slot: a single register with states EMPTY and PENDING.
  - `frm_valid` equals PENDING.
  - `frm_data` is stable while `frm_valid && !frm_ready`.
- Reset mid-operation: the accumulator, slot and `flush_pend` are cleared. The pending frame is lost.
- Reset values: `dct_buffer`=0, `dct_count`=0, `frm_valid`=0, `frm_data`=0, `overflow`=0, `busy`=0, `ovf_count`=0.

## Timing
- Accepted atom at cycle N: visible on `dct_buffer`/`dct_count` at N+1.
- Close at cycle N with the slot free: `frm_valid` at N+1, and `dct_count`=0 at N+1.
- Back-to-back frames: the slot can be refilled in the same cycle it is drained, giving a sustained 1 atom/cycle with no drop while `frm_ready` stays high.
- `overflow` is asserted in the cycle after the dropped atom's cycle.
- The handshake completes on any edge where `frm_valid && frm_ready`. `frm_valid` never drops without a handshake except on reset.

## Configuration
- `OCI_DCT_OVERFLOW_CNT_EN` defined:
  - Adds port `ovf_count[7:0]`, which increments on every `overflow` pulse and saturates at 255.
  - It is cleared only by reset.
- `OCI_DCT_OVERFLOW_CNT_EN` undefined:
  - The port and counter are absent.
  - `overflow` behaves identically to the defined case.

## Structure
- Package `oci_dct_pkg`:
  - `ATOM_W`, `DEPTH`, and the frame width.
  - Atom code enum (`DCT_NONE`, `DCT_NT`, `DCT_TK`, `DCT_IND`).
  - Accumulator state typedef (EMPTY/PART/FULL).
  - Slot state typedef.
- Sub-module `oci_dct_frame_slot`: a single-entry valid/ready holding register that exposes `load`, `free_next` and the output handshake.

## Test plan
- 15 atoms of 10 on consecutive cycles, `frm_ready`=1 → one frame `frm_data`=`{4'hF, 30'h2AAAAAAA}` at cycle 16; `dct_count`=0 afterward.
- Three atoms 01,10,11 then `flush` → frame `{4'h3, 30'h0000001B}`; `flush` while EMPTY → no frame.
- Hold `frm_ready`=0, send 30 atoms then 2 more → second frame held FULL, 2 `overflow` pulses, `ovf_count`=2 (macro on); raise `frm_ready` → two frames in order.
- Atom and `flush` in the same cycle at count 14 → a single frame with count 15, not an extra empty frame.
- `atom_code`=00 with `atom_valid`=1 → count unchanged, no overflow.
- Assert `reset_n`=0 while a frame is pending and count=7 → all outputs 0 immediately; no frame after release.
